selector_arbiter: RTL

Round-robin arbiter that shares the 4-way, 4-bit data selector between four requesters in the CPU datapath. Each requester raises a request; the arbiter grants one at a time, drives the selector's `s0`/`s1` select lines to route the owner's operand onto the shared bus, and limits each ownership to a bounded number of cycles. Its outputs connect directly to the selector's select inputs. Downstream logic uses `bus_valid` to qualify the selector output.

---
 rtl/selector_arbiter_pkg.sv | 25 ++
 rtl/selector_arbiter_rr_pick.sv | 36 +++
 rtl/selector_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/selector_arbiter_pkg.sv
// Shared constants and types for the selector arbiter.
// These constants match the CPU controller's selector_arb_defs.vh: the state
// encodings and the hold-counter width.
package selector_arbiter_pkg;

  localparam int unsigned N_REQ = 4;  // requesters / selector inputs
  localparam int unsigned IDX_W = 2;  // owner index width (s1,s0)
  localparam int unsigned CNT_W = 4;  // hold counter width

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Registered output bundle driven onto the selector and the bus qualifier.
  typedef struct packed {
    logic [N_REQ-1:0] gnt;
    logic [IDX_W-1:0] sel;
    logic             valid;
  } arb_out_t;

  // Converts an owner index into a one-hot grant vector.
  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/selector_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req [3:0] - request lines
//   ptr [1:0] - index with highest priority this round
//   any       - at least one request is set
//   idx [1:0] - first set request scanning upward from ptr, modulo 4
module rr_pick
  import selector_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_enc;

  // Rotate so that bit 0 of w_rot corresponds to req[ptr].
  assign w_dbl = {req, req};
  assign w_rot = N_REQ'(w_dbl >> ptr);

  // Fixed-priority encode: lowest set bit wins (scan downward, last hit sticks).
  always_comb begin
    w_enc = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_enc = IDX_W'(k);
    end
  end

  // Un-rotate; the 2-bit add wraps modulo 4.
  assign idx = w_enc + ptr;
  assign any = |req;

endmodule

// File: rtl/selector_arbiter.sv
// selector_arbiter: round-robin owner of the shared 4-way, 4-bit data selector.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req [3:0]     - request lines, req[i] routes in<i> to the bus
//   gnt [3:0]     - registered one-hot grant, zero when idle
//   s0, s1        - registered selector select lines (owner index), held while idle
//   bus_valid     - registered, high while a grant is active
// MAX_HOLD: maximum consecutive ownership cycles, legal range 1..15.
module selector_arbiter
  import selector_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             s0,
  output logic             s1,
  output logic             bus_valid
);

  logic [0:0]       r_state, w_state;
  arb_out_t         r_out,   w_out;
  logic [IDX_W-1:0] r_ptr,   w_ptr;
  logic [IDX_W-1:0] r_owner, w_owner;
  logic [CNT_W-1:0] r_cnt,   w_cnt;

  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic             w_release;

  rr_pick u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Owner gives up the bus when it stops asking or has used its full hold budget.
  assign w_release = !req[r_owner] || (r_cnt == CNT_W'(MAX_HOLD));

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_out   = r_out;
    w_ptr   = r_ptr;
    w_owner = r_owner;
    w_cnt   = r_cnt;
    if (r_state == ST_IDLE) begin
      if (w_any) begin
        w_state     = ST_BUSY;
        w_out.gnt   = idx_to_onehot(w_idx);
        w_out.sel   = w_idx;
        w_out.valid = 1'b1;
        w_owner     = w_idx;
        w_cnt       = CNT_W'(1);
      end
    end else begin
      if (w_release) begin
        // sel is left alone so the select lines stay quiet while idle.
        w_state     = ST_IDLE;
        w_out.gnt   = '0;
        w_out.valid = 1'b0;
        w_ptr       = r_owner + IDX_W'(1);
      end else begin
        w_cnt = r_cnt + CNT_W'(1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_out   <= w_out;
      r_ptr   <= w_ptr;
      r_owner <= w_owner;
      r_cnt   <= w_cnt;
    end
  end

  assign gnt       = r_out.gnt;
  assign s0        = r_out.sel[0];
  assign s1        = r_out.sel[1];
  assign bus_valid = r_out.valid;

endmodule
